// File: rtl/axi_addr_read_buffer.sv
// AXI read-address channel buffer: queues accepted AR beats in a small FIFO and
// presents the oldest entry to the read data stage over a valid/ready pair.
module axi_addr_read_buffer #(
    parameter int ADD_WIDTH    = 32,
    parameter int ADD_ID_WIDTH = 4,
    parameter int BURST_LEN    = 4,
    parameter int BURST_SIZE   = 3,
    parameter int BURST_TYPE   = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ADD_ID_WIDTH-1:0]       arid,
    input  logic [ADD_WIDTH-1:0]          araddr,
    input  logic [BURST_LEN-1:0]          arlen,
    input  logic [BURST_SIZE-1:0]         arsize,
    input  logic [BURST_TYPE-1:0]         arburst,
    input  logic                          arvalid,
    output logic                          arready,
    output logic [ADD_WIDTH-1:0]          raddr_out,
    output logic [BURST_LEN-1:0]          rlen_out,
    output logic [BURST_SIZE-1:0]         rsize_out,
    output logic [BURST_TYPE-1:0]         rburst_out,
    output logic [ADD_ID_WIDTH-1:0]       rid_out,
    output logic                          mod1_valid_out,
    input  logic                          mod1_ready_in,
    output logic [$clog2(FIFO_DEPTH):0]   count_out
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADD_ID_WIDTH + ADD_WIDTH + BURST_LEN + BURST_SIZE + BURST_TYPE;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               not_empty;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;

    // Handshakes: a transfer happens on a rising clk edge where valid && ready.
    // Both ready and valid come from registered count only, never from the
    // partner's valid/ready, so no combinational loop can form across the channel.
    assign not_empty      = (count != '0);
    assign arready        = !reset && (count != FULL_COUNT);
    assign mod1_valid_out = not_empty;
    assign push           = arvalid && arready;
    assign pop            = not_empty && mod1_ready_in && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: reads are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {arid, araddr, arlen, arsize, arburst};
    end

    assign head = not_empty ? mem[rd_ptr] : '0;
    assign {rid_out, raddr_out, rlen_out, rsize_out, rburst_out} = head;
    assign count_out = count;

endmodule

// File: tb/tb_axi_addr_read_buffer.sv
// Directed bench for axi_addr_read_buffer: hand-computed checks plus a queue
// model of the expected FIFO contents, compared after every clock edge.
module tb_axi_addr_read_buffer;

    localparam int EW = 45;  // id4 + addr32 + len4 + size3 + burst2

    logic        clk;
    logic        reset;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] raddr_out;
    logic [3:0]  rlen_out;
    logic [2:0]  rsize_out;
    logic [1:0]  rburst_out;
    logic [3:0]  rid_out;
    logic        mod1_valid_out;
    logic        mod1_ready_in;
    logic [2:0]  count_out;

    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    axi_addr_read_buffer dut (
        .clk(clk), .reset(reset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .raddr_out(raddr_out), .rlen_out(rlen_out), .rsize_out(rsize_out),
        .rburst_out(rburst_out), .rid_out(rid_out),
        .mod1_valid_out(mod1_valid_out), .mod1_ready_in(mod1_ready_in),
        .count_out(count_out)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        logic [EW-1:0] exp_head;
        exp_head = (exp_q.size() != 0) ? exp_q[0] : '0;
        check("m_arready", 64'(arready), 64'(!reset && exp_q.size() != 4));
        check("m_valid", 64'(mod1_valid_out), 64'(exp_q.size() != 0));
        check("m_count", 64'(count_out), 64'(exp_q.size()));
        check("m_head", 64'({rid_out, raddr_out, rlen_out, rsize_out, rburst_out}), 64'(exp_head));
    endtask

    // One clock: model predicts the handshakes from pre-edge inputs, then checks at edge+1.
    task automatic step();
        bit do_push;
        bit do_pop;
        logic [EW-1:0] ent;
        ent     = {arid, araddr, arlen, arsize, arburst};
        do_push = arvalid && !reset && (exp_q.size() != 4);
        do_pop  = (exp_q.size() != 0) && mod1_ready_in && !reset;
        @(posedge clk);
        if (reset) exp_q.delete();
        else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(ent);
        end
        #1;
        check_model();
    endtask

    // driver tasks
    task automatic drive_ar(input logic [3:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    endtask

    task automatic idle_ar();
        arvalid = 1'b0;
    endtask

    task automatic push_one(input logic [3:0] id);
        drive_ar(id, 32'h1000 + 32'(id) * 32'h10, 4'(id), 3'd3, 2'd1);
        step();
        idle_ar();
    endtask

    initial begin
        reset = 1'b1; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        arvalid = 1'b0; mod1_ready_in = 1'b0;
        step();
        step();
        check("rst_arready_low", 64'(arready), 64'd0);
        reset = 1'b0;
        #1;
        check("rst_count", 64'(count_out), 64'd0);
        check("rst_valid", 64'(mod1_valid_out), 64'd0);
        check("rst_arready_high", 64'(arready), 64'd1);

        // single beat latency
        drive_ar(4'd5, 32'h100, 4'd3, 3'd2, 2'd1);
        step();
        idle_ar();
        check("t1_valid", 64'(mod1_valid_out), 64'd1);
        check("t1_addr", 64'(raddr_out), 64'h100);
        check("t1_len", 64'(rlen_out), 64'd3);
        check("t1_size", 64'(rsize_out), 64'd2);
        check("t1_burst", 64'(rburst_out), 64'd1);
        check("t1_id", 64'(rid_out), 64'd5);
        check("t1_count", 64'(count_out), 64'd1);
        mod1_ready_in = 1'b1;
        step();
        mod1_ready_in = 1'b0;
        check("t1_drained", 64'(count_out), 64'd0);

        // fill, then attempt a fifth push
        for (int i = 1; i <= 4; i++) push_one(4'(i));
        check("t2_count", 64'(count_out), 64'd4);
        check("t2_arready", 64'(arready), 64'd0);
        check("t2_head_id", 64'(rid_out), 64'd1);
        drive_ar(4'd9, 32'hdead0, 4'd9, 3'd1, 2'd2);
        step();
        idle_ar();
        check("t2_full_count", 64'(count_out), 64'd4);
        check("t2_addr_hold", 64'(raddr_out), 64'h1010);

        // single pop from full
        mod1_ready_in = 1'b1;
        step();
        mod1_ready_in = 1'b0;
        check("t3_id", 64'(rid_out), 64'd2);
        check("t3_arready", 64'(arready), 64'd1);
        check("t3_count", 64'(count_out), 64'd3);

        // trim to 2 entries, then stream push+pop across pointer wrap
        mod1_ready_in = 1'b1;
        step();
        check("t4_pre_count", 64'(count_out), 64'd2);
        check("t4_pre_id", 64'(rid_out), 64'd3);
        for (int k = 0; k < 10; k++) begin
            drive_ar(4'(5 + k), 32'h1000 + 32'(5 + k) * 32'h10, 4'(5 + k), 3'd3, 2'd1);
            step();
            check("t4_count", 64'(count_out), 64'd2);
            check("t4_id", 64'(rid_out), 64'(4 + k));
        end
        idle_ar();
        mod1_ready_in = 1'b0;

        // reset with 3 queued and a live handshake on both sides
        push_one(4'd15);
        check("t5_pre_count", 64'(count_out), 64'd3);
        reset = 1'b1;
        mod1_ready_in = 1'b1;
        drive_ar(4'd7, 32'h777, 4'd7, 3'd7, 2'd3);
        step();
        check("t5_count", 64'(count_out), 64'd0);
        check("t5_valid", 64'(mod1_valid_out), 64'd0);
        check("t5_fields", 64'({rid_out, raddr_out, rlen_out, rsize_out, rburst_out}), 64'd0);
        reset = 1'b0;
        idle_ar();
        mod1_ready_in = 1'b0;
        #1;
        check("t5_arready", 64'(arready), 64'd1);
        step();
        check("t5_still_empty", 64'(count_out), 64'd0);

        // drain to empty, keep popping, then verify pointers stayed aligned
        push_one(4'd10);
        push_one(4'd11);
        mod1_ready_in = 1'b1;
        step();
        check("t6_id", 64'(rid_out), 64'd11);
        step();
        step();
        check("t6_valid", 64'(mod1_valid_out), 64'd0);
        check("t6_count", 64'(count_out), 64'd0);
        check("t6_fields", 64'({rid_out, raddr_out, rlen_out, rsize_out, rburst_out}), 64'd0);
        mod1_ready_in = 1'b0;
        push_one(4'd12);
        check("t6_after_id", 64'(rid_out), 64'd12);
        check("t6_after_addr", 64'(raddr_out), 64'h10c0);
        check("t6_after_count", 64'(count_out), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
